// File: rtl/example_data_bus_pkg.sv
// Shared types for the pipelined data memory bus: response FIFO entry,
// in-flight request tag and the latency ceiling.
package example_data_bus_pkg;

  localparam int MAX_READ_LATENCY = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_entry_t;

  typedef struct packed {
    logic valid;
    logic is_write;
    logic err;
  } tag_t;

  localparam int RSP_ENTRY_W = $bits(rsp_entry_t);

endpackage

// File: rtl/example_data_bus_rsp_fifo.sv
// In-order response FIFO: synchronous push/pop, power-of-two depth,
// pointers carry one wrap bit so full and empty are distinguishable.
module example_data_bus_rsp_fifo
  import example_data_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [RSP_ENTRY_W-1:0] din,
  output logic [RSP_ENTRY_W-1:0] dout,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            wptr, rptr;
  logic [RSP_ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset: an entry is only visible once its push moved wptr.
  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/example_data_memory_bus_pipelined.sv
// Pipelined load/store bus to a synchronous data memory with in-order responses.
// Define EXAMPLE_DATA_BUS_RANGE_CHECK_EN to decode ADDR_BEGIN..ADDR_END and flag misses.
module example_data_memory_bus_pipelined
  import example_data_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BEGIN    = 32'h8000_0000,
  parameter logic [31:0] ADDR_END      = 32'h8001_FFFF,
  parameter int          MEM_WORD_BITS = 15,
  parameter int          READ_LATENCY  = 1,
  parameter int          RSP_DEPTH     = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [3:0]               req_be,
  input  logic                     req_we,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [MEM_WORD_BITS-1:0] mem_address,
  output logic                     mem_wren,
  output logic [3:0]               mem_byteena,
  output logic [31:0]              mem_data,
  input  logic [31:0]              mem_q
);

  localparam int LAT = (READ_LATENCY < 1) ? 1 :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
  localparam int CW  = $clog2(RSP_DEPTH + 1);

  logic          accept, in_range;
  tag_t          tag_in;
  tag_t [LAT:1]  tag_pipe;
  logic [CW-1:0] credits, credits_nxt;
  logic          ready_q;
  logic          push, pop, fifo_empty, fifo_full;
  rsp_entry_t    push_entry, head;

  assign req_ready = ready_q;
  assign accept    = req_valid && ready_q;

`ifdef EXAMPLE_DATA_BUS_RANGE_CHECK_EN
  assign in_range = (req_addr >= ADDR_BEGIN) && (req_addr <= ADDR_END);
`else
  // Without decode every address maps onto the memory, upper bits alias.
  assign in_range = 1'b1;
  logic unused_ok;
  assign unused_ok = &{1'b0, req_addr[31:MEM_WORD_BITS+2], req_addr[1:0],
                       head.err, ADDR_BEGIN, ADDR_END};
`endif

  assign mem_address = req_addr[MEM_WORD_BITS+1:2];
  assign mem_byteena = req_be;
  assign mem_data    = req_wdata;
  assign mem_wren    = accept && req_we && in_range;

  always_comb begin
    tag_in          = '0;
    tag_in.valid    = accept;
    tag_in.is_write = req_we;
    tag_in.err      = !in_range;
  end

  // Tag travels alongside the memory read so it exits when mem_q is valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= tag_in;
      for (int k = 2; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.err   = tag_pipe[LAT].err;
    push_entry.rdata = (!tag_pipe[LAT].is_write && !tag_pipe[LAT].err) ? mem_q : 32'h0;
  end

  assign push = tag_pipe[LAT].valid;
  assign pop  = !fifo_empty && rsp_ready;

  example_data_bus_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (push_entry),
    .dout    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Credits count requests in flight plus responses waiting; ready is
  // registered so rsp_ready never reaches req_ready combinationally.
  assign credits_nxt = credits + CW'(accept) - CW'(pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits <= '0;
      ready_q <= 1'b0;
    end else begin
      credits <= credits_nxt;
      ready_q <= (credits_nxt < CW'(RSP_DEPTH));
    end
  end

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = fifo_empty ? 32'h0 : head.rdata;
`ifdef EXAMPLE_DATA_BUS_RANGE_CHECK_EN
  assign rsp_err   = !fifo_empty && head.err;
`else
  assign rsp_err   = 1'b0;
`endif

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(push && fifo_full));

endmodule

// File: tb/tb_example_data_memory_bus_pipelined.sv
// Scoreboard bench: stimulus pushes expected responses from a word-array
// reference model; a negedge monitor pops and compares DUT responses.
module tb_example_data_memory_bus_pipelined;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
`ifdef EXAMPLE_DATA_BUS_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_wren;
  logic [31:0] rsp_rdata, mem_data, mem_q;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteena;

  example_data_memory_bus_pipelined #(.READ_LATENCY(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_byteena(mem_byteena),
    .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // External memory macro: synchronous read, LAT cycles address-to-data.
  bit   [31:0] mem_arr [0:32767];
  logic [31:0] q0 = '0, q1 = '0;
  always @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (mem_wren && mem_byteena[b]) mem_arr[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
    q0 <= mem_arr[mem_address];
    q1 <= q0;
  end
  assign mem_q = q1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          exact;
  } exp_t;

  exp_t        exp_q[$];
  bit   [31:0] ref_mem [0:32767];
  int          n_chk = 0, n_fail = 0, n_acc = 0, cyc = 0;
  bit          rsp_always = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return !RANGE_EN || ((a >= 32'h8000_0000) && (a <= 32'h8001_FFFF));
  endfunction

  // Reference: whole-word memory updated in acceptance order.
  task automatic ref_accept();
    exp_t        e;
    int          w;
    bit          ir;
    w  = int'(req_addr[16:2]);
    ir = in_rng(req_addr);
    e.err   = !ir;
    e.acc   = cyc;
    e.exact = rsp_always;
    e.rdata = 32'h0;
    if (req_we) begin
      if (ir) for (int b = 0; b < 4; b++)
        if (req_be[b]) ref_mem[w][8*b +: 8] = req_wdata[8*b +: 8];
    end else if (ir) begin
      e.rdata = ref_mem[w];
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    bit          stall;
    logic [31:0] prv_d;
    logic        prv_e;
    exp_t        e;
    stall = 1'b0;
    prv_d = '0;
    prv_e = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        stall = 1'b0;
      end else begin
        chk("mem_wren", mem_wren, req_valid && req_ready && req_we && in_rng(req_addr));
        if (req_valid && req_ready) begin
          n_acc++;
          chk("mem_address", mem_address, req_addr[16:2]);
          ref_accept();
        end
        if (stall) begin
          chk("hold_valid", rsp_valid, 1'b1);
          chk("hold_rdata", rsp_rdata, prv_d);
          chk("hold_err", rsp_err, prv_e);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response", rsp_rdata, rsp_err);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            if (e.exact) chk("rsp_latency", cyc - e.acc, LAT + 1);
          end
        end
        stall = rsp_valid && !rsp_ready;
        prv_d = rsp_rdata;
        prv_e = rsp_err;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] d,
                       input logic [3:0] be, input bit rnd);
    int n = 0;
    req_addr = a; req_we = we; req_wdata = d; req_be = be; req_valid = 1'b1;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      @(posedge clock); #1;
      if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      n++;
    end
    chk("issue_accepted", req_ready, 1'b1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clock);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_mem_wren", mem_wren, 1'b0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_release_ready", req_ready, 1'b1);
    @(posedge clock); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          c0, a0;
    logic [31:0] a;
    do_reset();

    // Store then load to the same word on the next cycle
    rsp_always = 1'b1;
    issue(32'h8000_0010, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
    issue(32'h8000_0010, 1'b0, 32'h0, 4'hF, 1'b0);
    drain();

    // Back-to-back loads: one accept per cycle, exact latency each
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      issue(32'h8000_0000 + ($urandom_range(0, 15) << 2), 1'b0, 32'h0, 4'hF, 1'b0);
    chk("b2b_cycles", cyc - c0, 16);
    drain();

    // Range boundaries and out-of-range / aliasing accesses
    issue(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b0);
    issue(32'h8002_0000, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0);
    issue(32'h8000_0000, 1'b0, 32'h0, 4'hF, 1'b0);
    issue(32'h8001_FFFC, 1'b1, 32'h0BAD_CAFE, 4'h5, 1'b0);
    issue(32'h8001_FFFC, 1'b0, 32'h0, 4'hF, 1'b0);
    issue(32'h7FFF_FFFC, 1'b0, 32'h0, 4'hF, 1'b0);
    drain();

    // Backpressure: four accepted, fifth stalls until the consumer drains
    rsp_always = 1'b0;
    rsp_ready  = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 4; i++) issue(32'h8000_0000 + (i << 2), 1'b0, 32'h0, 4'hF, 1'b0);
    req_addr = 32'h8000_0010; req_we = 1'b0; req_valid = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("bp_ready_low", req_ready, 1'b0);
    end
    chk("bp_accepted", n_acc - a0, 4);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    issue(32'h8000_0010, 1'b0, 32'h0, 4'hF, 1'b0);
    issue(32'h8000_0014, 1'b0, 32'h0, 4'hF, 1'b0);
    drain();
    chk("bp_total", n_acc - a0, 6);

    // Mid-stream reset with two loads in flight: both are dropped
    rsp_always = 1'b1;
    issue(32'h8000_0010, 1'b0, 32'h0, 4'hF, 1'b0);
    issue(32'h8000_0014, 1'b0, 32'h0, 4'hF, 1'b0);
    do_reset();
    repeat (6) begin
      @(negedge clock);
      chk("no_stale_rsp", rsp_valid, 1'b0);
    end
    @(posedge clock); #1;

    // Randomized traffic with random consumer stalls and idle gaps
    rsp_always = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'h8001_FFF0 + ($urandom_range(0, 7) << 2);
        default: a = 32'h8000_0000 + ($urandom_range(0, 15) << 2);
      endcase
      issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
    drain();
    repeat (3) @(negedge clock);
    chk("final_rsp_valid", rsp_valid, 1'b0);
    chk("final_req_ready", req_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/example_data_memory_bus_pipelined.md
# example_data_memory_bus_pipelined

Pipelined, parametrised successor to the single-cycle data memory bus. It accepts load/store requests from the core over a valid/ready handshake and drives a synchronous data memory with configurable read latency. It returns one in-order response per request, with backpressure, through a small response FIFO, and optionally flags out-of-range accesses. It sits between the rvsimple core's data port and the external data memory macro.

## Interface
- ADDR_BEGIN, 32'h8000_0000, first byte address decoded to memory
- ADDR_END, 32'h8001_FFFF, last byte address decoded to memory (inclusive)
- MEM_WORD_BITS, 15, width of the memory word address
- READ_LATENCY, 1, cycles from address presented to mem_q valid; legal range 1..4
- RSP_DEPTH, 4, response FIFO entries; power of two; must be >= READ_LATENCY+2 for one request per cycle
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables
- req_we  in  1  1 = store, 0 = load
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  access was out of range
- mem_address  out  MEM_WORD_BITS  word address, req_addr[MEM_WORD_BITS+1:2]
- mem_wren  out  1  write strobe
- mem_byteena  out  4  byte enables to memory
- mem_data  out  32  write data to memory
- mem_q  in  32  read data, READ_LATENCY cycles after address

## Operation
- Accept = req_valid && req_ready. in_range = ADDR_BEGIN <= req_addr <= ADDR_END (unsigned 32-bit compare).
- mem_address, mem_byteena and mem_data are combinational copies of the request fields in every cycle. mem_wren = accept && req_we && in_range.
- Each accepted request, load or store, enters a READ_LATENCY-stage tag pipeline. A tag holds {valid, is_write, err}, with err = !in_range.
- At pipeline exit the FIFO pushes {rdata, err}:
  - valid load with err=0: rdata = mem_q.
  - store or err=1: rdata = 32'h0.
- Responses leave in acceptance order. rsp_valid = FIFO not empty. Pop = rsp_valid && rsp_ready.
- Credit counter, 0..RSP_DEPTH: +1 on accept, -1 on pop; an accept and a pop in the same cycle leave it unchanged. req_ready = (count < RSP_DEPTH), a registered value only, with no combinational path from rsp_ready. The FIFO therefore never overflows, and a push into a full FIFO is an assertion failure.
- Out-of-range loads never reach memory. Out-of-range stores never assert mem_wren.
- Loads are not forwarded from stores. A load accepted in the cycle after a store to the same word sees the memory's post-write contents.

## Timing
- Reset (reset_n low, asynchronous) clears the tag pipeline, FIFO pointers and credit counter. In-flight requests are dropped and no response is issued for them.
- Outputs during reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wren=0.
- req_ready rises to 1 in the first cycle after reset_n deasserts.
- A request accepted in cycle T has mem_q sampled in cycle T+READ_LATENCY, pushed at the end of that cycle, with rsp_valid high from cycle T+READ_LATENCY+1.
- With rsp_ready held at 1 and RSP_DEPTH >= READ_LATENCY+2, the block sustains one request per cycle.
- While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err are held stable.

## Configuration
- EXAMPLE_DATA_BUS_RANGE_CHECK_EN defined: behaviour as above.
- Not defined:
  - in_range is forced to 1, so ADDR_BEGIN and ADDR_END are unused and upper address bits are ignored (aliasing).
  - rsp_err is tied to 0.
  - Every store asserts mem_wren on accept.

## Structure
- Package example_data_bus_pkg holds:
  - typedef rsp_entry_t {logic[31:0] rdata; logic err;}
  - typedef tag_t {logic valid, is_write, err;}
  - constant MAX_READ_LATENCY = 4.
- Sub-module example_data_bus_rsp_fifo: parametrised by depth, synchronous push/pop, asynchronous active-low reset, empty/full outputs.
- Top level holds the decode, the tag pipeline and the credit counter.

## Test plan
- Reset: hold reset_n=0 for 3 cycles, including a mid-stream reset with 2 loads in flight -> all outputs 0, no stale response after release, req_ready=1 in the next cycle.
- Load after store (READ_LATENCY=1):
  - store 32'hDEADBEEF to 32'h8000_0010 with be=4'hF -> mem_wren=1 for one cycle; response rdata=0, err=0.
  - next-cycle load from the same address -> rsp_valid in cycle T+2 with rdata=32'hDEADBEEF.
- Back-to-back: 16 loads on consecutive cycles, rsp_ready=1, READ_LATENCY=2, RSP_DEPTH=4 -> req_ready never drops; responses arrive in order, one per cycle.
- Backpressure: rsp_ready=0, issue 6 loads, RSP_DEPTH=4 -> exactly 4 accepted and req_ready=0. Then raise rsp_ready -> responses drain in order and the remaining 2 loads are accepted.
- Range (macro defined): load from 32'h0000_0100 -> rsp_err=1, rdata=0, no memory read. Store to 32'h8002_0000 -> mem_wren stays 0, rsp_err=1.
- Macro undefined: the same store to 32'h8002_0000 -> mem_wren=1, mem_address=15'h0000, rsp_err=0.
